// File: rtl/sr_exciter_pkg.sv
// sr_exciter_pkg: shared types and constants for the SR latch exciter.
// Holds the controller state encoding, default hold/timeout lengths, the
// countdown width and the feedback-match helper used by the controller.
package sr_exciter_pkg;

  // Width of the shared hold/timeout countdown (covers 1..15 cycles).
  localparam int unsigned CNT_W = 4;

  // Default number of cycles S or R is held asserted per write.
  localparam int unsigned HOLD_CYC_DEF = 2;

  // Default number of WAIT cycles allowed for the latch to confirm.
  localparam int unsigned TIMEOUT_DEF = 8;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  // Latch feedback confirms the target value only when Q equals the target
  // and Q_L is its complement; Q==Q_L (metastable/forbidden) never matches.
  function automatic logic fb_match(input logic q, input logic ql, input logic d);
    return (q == d) && (ql == ~d);
  endfunction

endpackage

// File: rtl/sr_timer.sv
// sr_timer: small loadable down-counter shared by the hold and timeout phases.
// A load takes priority over a decrement; the count stops at zero and the
// zero flag is a plain decode of the current count.
module sr_timer
  import sr_exciter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_l,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Countdown register: reload per phase, otherwise decrement toward zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sr_exciter.sv
// sr_exciter: drives S/R of an external SR latch to write a requested value,
// then waits for the latch feedback to confirm it (ACK) or times out (ERR).
// Optional feature macro: SR_EXCITER_ERRCNT_EN adds ERR_CNT[7:0], a
// saturating count of ERR pulses.
module sr_exciter
  import sr_exciter_pkg::*;
#(
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST_L,
  input  logic       REQ,
  input  logic       D,
  input  logic       Q_FB,
  input  logic       QL_FB,
  output logic       S,
  output logic       R,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR
`ifdef SR_EXCITER_ERRCNT_EN
  ,
  output logic [7:0] ERR_CNT
`endif
);

  // The countdown reaches zero on the last cycle of a phase, so load N-1.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  logic             r_dcap;
  logic             w_dcap_next;
  logic             w_match_in;
  logic             w_match_cap;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic             r_s;
  logic             r_r;
  logic             r_busy;
  logic             r_ack;
  logic             r_err;

  // In IDLE the target is still on D (captured at this same edge), so the
  // early-match test looks at D; afterwards it uses the captured value.
  assign w_match_in  = fb_match(Q_FB, QL_FB, D);
  assign w_match_cap = fb_match(Q_FB, QL_FB, r_dcap);

  sr_timer u_timer (
    .i_clk      (CLK),
    .i_rst_l    (RST_L),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Next-state, capture and timer control.
  always_comb begin
    w_next      = r_state;
    w_dcap_next = r_dcap;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (REQ) begin
          w_dcap_next = D;
          if (w_match_in) begin
            w_next = ST_DONE;
          end else begin
            w_next     = ST_DRIVE;
            w_tmr_load = 1'b1;
            w_tmr_val  = HOLD_LOAD;
          end
        end
      end
      ST_DRIVE: begin
        if (w_tmr_zero) begin
          w_next     = ST_WAIT;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMO_LOAD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_match_cap) begin
          w_next = ST_DONE;
        end else if (w_tmr_zero) begin
          w_next = ST_FAIL;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_FAIL: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, captured target and registered outputs. Outputs are decoded from
  // the next state so they line up with the state they describe; S and R are
  // both gated by DRIVE and split by one bit, so 11 cannot occur.
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      r_state <= ST_IDLE;
      r_dcap  <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dcap  <= w_dcap_next;
      r_s     <= (w_next == ST_DRIVE) &&  w_dcap_next;
      r_r     <= (w_next == ST_DRIVE) && !w_dcap_next;
      r_busy  <= (w_next != ST_IDLE);
      r_ack   <= (w_next == ST_DONE);
      r_err   <= (w_next == ST_FAIL);
    end
  end

  assign S    = r_s;
  assign R    = r_r;
  assign BUSY = r_busy;
  assign ACK  = r_ack;
  assign ERR  = r_err;

`ifdef SR_EXCITER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of timeouts; steps on the same edge that raises ERR.
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      r_err_cnt <= '0;
    end else if ((w_next == ST_FAIL) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign ERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_sr_exciter.sv
// tb_sr_exciter: drives sr_exciter into a behavioural master-slave SR latch
// with programmable feedback delay, and checks every output on every cycle
// against a transaction-offset reference model, plus directed scenarios with
// hand-computed expectations. Honours SR_EXCITER_ERRCNT_EN when defined.
`timescale 1ns/1ps
module tb_sr_exciter;

  localparam int HB = 2;
  localparam int TB = 8;

  logic CLK = 1'b0;
  logic RST_L, REQ, D, Q_FB, QL_FB;
  logic S, R, BUSY, ACK, ERR;
`ifdef SR_EXCITER_ERRCNT_EN
  logic [7:0] ERR_CNT;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 CLK = ~CLK;

  sr_exciter #(.HOLD_CYC(HB), .TIMEOUT(TB)) dut (
    .CLK     (CLK),
    .RST_L   (RST_L),
    .REQ     (REQ),
    .D       (D),
    .Q_FB    (Q_FB),
    .QL_FB   (QL_FB),
    .S       (S),
    .R       (R),
    .BUSY    (BUSY),
    .ACK     (ACK),
`ifdef SR_EXCITER_ERRCNT_EN
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT)
`else
    .ERR     (ERR)
`endif
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- SR latch model with delayed feedback ----------------
  int unsigned lat_delay;
  bit          lat_stuck;
  bit          lat_load;
  logic        lat_val;
  logic        lq;
  logic [15:0] hist;

  always @(negedge CLK) begin
    if (lat_load) begin
      lq   = lat_val;
      hist = {16{lat_val}};
    end else begin
      if (S === 1'b1) lq = 1'b1;
      else if (R === 1'b1) lq = 1'b0;
      hist = {hist[14:0], lq};
    end
    Q_FB  = lat_stuck ? 1'b1 : hist[lat_delay];
    QL_FB = lat_stuck ? 1'b1 : ~hist[lat_delay];
  end

  // ---------------- reference model ----------------
  // A write accepted at edge t0 expects: DRIVE for offsets 1..HB, WAIT
  // for offsets HB+1..HB+TB, then ACK right after the first WAIT cycle whose
  // feedback matches, or ERR after the last WAIT cycle.
  bit   e_valid = 1'b0;
  logic e_s, e_r, e_busy, e_ack, e_err;
  int   e_cnt = 0;
  bit   m_active = 1'b0;
  bit   m_final = 1'b0;
  logic m_d;
  int   m_t0;
  int   m_edge = 0;

  always @(posedge CLK) begin
    int j;
    bit mt;
    m_edge++;
    e_s = 1'b0; e_r = 1'b0; e_busy = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    if (RST_L !== 1'b1) begin
      e_valid  = 1'b1;
      m_active = 1'b0;
      m_final  = 1'b0;
      e_cnt    = 0;
    end else if (m_active) begin
      if (m_final) begin
        m_active = 1'b0;
        m_final  = 1'b0;
      end else begin
        j  = m_edge - m_t0;
        mt = (Q_FB === m_d) && (QL_FB === ~m_d);
        e_busy = 1'b1;
        if (j < HB) begin
          e_s = m_d; e_r = ~m_d;
        end else if (j > HB && mt) begin
          e_ack = 1'b1; m_final = 1'b1;
        end else if (j == HB + TB) begin
          e_err = 1'b1; m_final = 1'b1;
          if (e_cnt < 255) e_cnt++;
        end
      end
    end else if (REQ === 1'b1) begin
      m_active = 1'b1;
      m_t0     = m_edge;
      m_d      = D;
      e_busy   = 1'b1;
      if ((Q_FB === D) && (QL_FB === ~D)) begin
        e_ack = 1'b1; m_final = 1'b1;
      end else begin
        e_s = D; e_r = ~D;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge CLK) begin
    if (e_valid) begin
      chk1("S", S, e_s);
      chk1("R", R, e_r);
      chk1("BUSY", BUSY, e_busy);
      chk1("ACK", ACK, e_ack);
      chk1("ERR", ERR, e_err);
      chk1("S_and_R", S & R, 1'b0);
      chk1("ACK_and_ERR", ACK & ERR, 1'b0);
`ifdef SR_EXCITER_ERRCNT_EN
      chkn("ERR_CNT", int'(ERR_CNT), e_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic ob_s [16];
  logic ob_r [16];
  logic ob_busy [16];
  logic ob_ack [16];
  logic ob_err [16];
  int   ob_cnt [16];

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic preset(input logic v, input int unsigned dly);
    lat_val   = v;
    lat_delay = dly;
    lat_load  = 1'b1;
    @(negedge CLK);
    #1;
    lat_load = 1'b0;
  endtask

  // Issue one request in the current cycle (cycle 0) and record outputs in
  // cycles 1..nk; optionally pull reset low during cycle rst_at.
  task automatic run_req(input logic d, input int nk, input int rst_at);
    REQ = 1'b1;
    D   = d;
    for (int k = 1; k <= nk; k++) begin
      @(negedge CLK);
      ob_s[k]    = S;
      ob_r[k]    = R;
      ob_busy[k] = BUSY;
      ob_ack[k]  = ACK;
      ob_err[k]  = ERR;
`ifdef SR_EXCITER_ERRCNT_EN
      ob_cnt[k]  = int'(ERR_CNT);
`else
      ob_cnt[k]  = 0;
`endif
      #1;
      REQ   = 1'b0;
      RST_L = (k == rst_at) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    int nerr;
    RST_L = 1'b0; REQ = 1'b0; D = 1'b0;
    lat_delay = 0; lat_stuck = 1'b0; lat_load = 1'b1; lat_val = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    RST_L = 1'b1; lat_load = 1'b0;
    idle(2);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_S", S, 1'b0);

    // Latch Q=0, write 1, feedback 3 cycles late: ACK in cycle 5.
    preset(1'b0, 3);
    idle(1);
    run_req(1'b1, 8, 0);
    for (int k = 1; k <= 8; k++) begin
      chk1("w1_S", ob_s[k], (k <= 2) ? 1'b1 : 1'b0);
      chk1("w1_R", ob_r[k], 1'b0);
      chk1("w1_ACK", ob_ack[k], (k == 5) ? 1'b1 : 1'b0);
      chk1("w1_BUSY", ob_busy[k], (k <= 5) ? 1'b1 : 1'b0);
      chk1("w1_ERR", ob_err[k], 1'b0);
    end

    // Latch already 1, write 1: immediate ACK, no excitation.
    preset(1'b1, 0);
    idle(1);
    run_req(1'b1, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      chk1("early_ACK", ob_ack[k], (k == 1) ? 1'b1 : 1'b0);
      chk1("early_BUSY", ob_busy[k], (k == 1) ? 1'b1 : 1'b0);
      chk1("early_S", ob_s[k], 1'b0);
      chk1("early_R", ob_r[k], 1'b0);
    end

    // Stuck feedback Q=QL=1, write 0: R cycles 1-2, ERR cycle 11.
    lat_stuck = 1'b1;
    idle(1);
    run_req(1'b0, 13, 0);
    for (int k = 1; k <= 13; k++) begin
      chk1("tmo_R", ob_r[k], (k <= 2) ? 1'b1 : 1'b0);
      chk1("tmo_S", ob_s[k], 1'b0);
      chk1("tmo_ERR", ob_err[k], (k == 11) ? 1'b1 : 1'b0);
      chk1("tmo_ACK", ob_ack[k], 1'b0);
      chk1("tmo_BUSY", ob_busy[k], (k <= 11) ? 1'b1 : 1'b0);
    end
`ifdef SR_EXCITER_ERRCNT_EN
    chkn("tmo_ERR_CNT", ob_cnt[13], 1);
`endif
    lat_stuck = 1'b0;

    // REQ held high with alternating D; the model checks every cycle.
    preset(1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      REQ = 1'b1;
      D   = (i % 2 == 0) ? 1'b1 : 1'b0;
      idle(1);
    end
    REQ = 1'b0;
    idle(15);

    // Reset in DRIVE cycle 2: everything clears at the next edge.
    preset(1'b0, 0);
    idle(1);
    run_req(1'b1, 6, 2);
    chk1("abort_S1", ob_s[1], 1'b1);
    chk1("abort_S2", ob_s[2], 1'b1);
    for (int k = 3; k <= 6; k++) begin
      chk1("abort_S", ob_s[k], 1'b0);
      chk1("abort_R", ob_r[k], 1'b0);
      chk1("abort_BUSY", ob_busy[k], 1'b0);
      chk1("abort_ACK", ob_ack[k], 1'b0);
      chk1("abort_ERR", ob_err[k], 1'b0);
    end

    // Randomized traffic with random delays, stuck feedback and resets.
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        lat_delay = $urandom_range(0, 12);
        lat_stuck = ($urandom_range(0, 7) == 0);
      end
      REQ   = ($urandom_range(0, 2) == 0);
      D     = $urandom_range(0, 1) == 1;
      RST_L = ($urandom_range(0, 199) != 0);
      idle(1);
    end
    REQ = 1'b0; RST_L = 1'b1; lat_stuck = 1'b0;
    idle(20);

    // 260 forced timeouts from a clean reset.
    RST_L = 1'b0;
    idle(1);
    RST_L = 1'b1; lat_stuck = 1'b1; REQ = 1'b1;
    nerr = 0;
    for (int i = 0; i < 4000 && nerr < 260; i++) begin
      D = $urandom_range(0, 1) == 1;
      @(negedge CLK);
      if (ERR === 1'b1) nerr++;
      #1;
    end
    REQ = 1'b0;
    chkn("sat_err_pulses", nerr, 260);
    idle(3);
`ifdef SR_EXCITER_ERRCNT_EN
    chkn("sat_ERR_CNT", int'(ERR_CNT), 255);
`endif
    lat_stuck = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sr_exciter.md
SR_EXCITER -- requirements
Module: sr_exciter

Interface
REQ-001 Parameter HOLD_CYC, default 2: number of cycles S or R is held asserted per write, legal range 1..15.
REQ-002 Parameter TIMEOUT, default 8: maximum number of WAIT cycles for feedback to confirm, legal range 1..15.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST_L  input  1  reset, synchronous and active-low.
REQ-005 REQ  input  1  write request; sampled only in IDLE.
REQ-006 D  input  1  target latch value, captured with REQ.
REQ-007 Q_FB  input  1  latch Q feedback.
REQ-008 QL_FB  input  1  latch Q_L feedback.
REQ-009 S  output  1  latch set excitation, registered.
REQ-010 R  output  1  latch reset excitation, registered.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 ACK  output  1  one-cycle pulse: write confirmed.
REQ-013 ERR  output  1  one-cycle pulse: confirmation timeout.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, WAIT, DONE and FAIL.
REQ-015 Feedback "match" SHALL mean Q_FB==D_cap and QL_FB==~D_cap; Q_FB==QL_FB SHALL never count as a match.
REQ-016 REQ=1 in IDLE at edge n SHALL capture D into D_cap; REQ outside IDLE SHALL be ignored, with no queueing.
REQ-017 If feedback matches when REQ is sampled, the FSM SHALL go to DONE: ACK=1 in cycle n+1, S and R stay 0.
REQ-018 Otherwise the FSM SHALL go to DRIVE with S=D_cap and R=~D_cap for exactly HOLD_CYC cycles (n+1..n+HOLD_CYC).
REQ-019 After DRIVE, S and R SHALL both be 0 and the FSM SHALL enter WAIT.
REQ-020 Each WAIT cycle SHALL test for a match; a match in WAIT cycle k SHALL give DONE, with ACK=1 in cycle k+1.
REQ-021 If no match occurs within TIMEOUT WAIT cycles, the FSM SHALL go to FAIL, with ERR=1 for one cycle.
REQ-022 DONE and FAIL SHALL each last one cycle and then return to IDLE; a new REQ is accepted in the following cycle.
REQ-023 S and R SHALL never be 1 in the same cycle; the forbidden 11 input to the latch SHALL be unreachable by construction.
REQ-024 ACK and ERR SHALL never be 1 in the same cycle.
REQ-025 BUSY SHALL rise in the cycle after REQ is accepted and fall in the cycle after DONE or FAIL.

Reset
REQ-026 RST_L=0 at an edge SHALL force IDLE, S=0, R=0, BUSY=0, ACK=0, ERR=0 and D_cap=0, with the counters cleared.
REQ-027 Reset during DRIVE or WAIT SHALL abort the write with no ACK or ERR; excitation SHALL be 0 from the next edge.

Configuration
REQ-028 With SR_EXCITER_ERRCNT_EN defined, the block SHALL add output ERR_CNT[7:0]: a saturating count of ERR pulses, reset to 0, holding at 255.
REQ-029 Without SR_EXCITER_ERRCNT_EN, the ERR_CNT port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 Package sr_exciter_pkg SHALL hold the state enum, the default HOLD_CYC and TIMEOUT constants, and the 4-bit counter width.
REQ-031 Sub-module sr_timer SHALL be used for the hold and timeout countdowns (4-bit, load/decrement/zero flag), instantiated once and reloaded per phase.
REQ-032 The bench SHALL connect S/R to a behavioural master-slave SR latch model whose feedback delay is programmable.

Verification (HOLD_CYC=2, TIMEOUT=8)
REQ-033 Latch Q=0, REQ=1 D=1 at cycle 0 -> S=1 in cycles 1-2, R=0 throughout, and ACK exactly one cycle after Q_FB=1/QL_FB=0 is seen in WAIT.
REQ-034 Latch Q=1, REQ=1 D=1 -> ACK in cycle 1, S=R=0 throughout, BUSY high in cycle 1 only.
REQ-035 Feedback stuck Q_FB=QL_FB=1, REQ D=0 -> R=1 in cycles 1-2, WAIT in cycles 3-10, ERR in cycle 11, no ACK; with SR_EXCITER_ERRCNT_EN, ERR_CNT=1.
REQ-036 REQ held high for 20 cycles with alternating D -> one write per IDLE visit, and S&R==0 asserted in every cycle.
REQ-037 RST_L=0 in cycle 2 of DRIVE -> S=R=0, BUSY=0 and IDLE at the next edge, with no ACK or ERR.
REQ-038 With SR_EXCITER_ERRCNT_EN, 260 forced timeouts -> ERR_CNT saturates at 255.
